pipe_stage_chain: RTL
=====================

Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed decode-to-execute register: a chain of DEPTH pipeline slots carrying a CTRL_W-bit control field and a DATA_W-bit payload.
- Each slot has a valid bit and a valid/ready handshake, so flush, stall and bubble-collapse are handled in one block.
- Used between any two pipeline stages, and for multi-cycle stage paths such as multiplier or memory latency.

Parameters:
- DEPTH, 1, number of register slots (1..8); latency in cycles when never stalled.
- CTRL_W, 8, control-field width; zeroed on flush and reset.
- DATA_W, 64, payload width.
- CLEAR_DATA, 0, 1 means flush and reset also zero the payload; 0 means the payload holds its previous value.
- COLLAPSE, 1, 1 means a slot may fill while a later slot is stalled (bubble collapse); 0 means the whole chain freezes on stall.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream holds a valid entry
- in_ready  out  1  chain accepts the entry this cycle
- in_ctrl  in  CTRL_W  control field
- in_data  in  DATA_W  payload
- flush  in  1  kill all in-flight entries and refuse input this cycle
- out_valid  out  1  last slot is valid
- out_ready  in  1  downstream consumes this cycle
- out_ctrl  out  CTRL_W  last-slot control; zero when out_valid=0
- out_data  out  DATA_W  last-slot payload
- occupancy  out  4  count of valid slots, 0..DEPTH

Behaviour:
- Reset values: all slot valid=0, all ctrl=0, occupancy=0. Payload=0 if CLEAR_DATA=1, otherwise unchanged.
- Slots are numbered 0 (input) to DEPTH-1 (output). Define ready[DEPTH] = out_ready.
- COLLAPSE=1: ready[i] = !valid[i] | ready[i+1].
- COLLAPSE=0: ready[i] = out_ready | !out_valid for all i.
- in_ready = ready[0] & !flush & !reset. It is combinational and has no dependency on in_valid.
- Slot i loads from slot i-1 (slot 0 loads from the inputs) when ready[i]=1. The new valid is the upstream valid and the handshake.
- A slot whose upstream is empty or not handing over becomes valid=0, with ctrl forced to 0.
- A slot with ready[i]=0 holds all of its fields.
- out_valid = valid[DEPTH-1]. out_ctrl is gated to 0 when out_valid=0.
- An accepted entry with no stalls appears at the output exactly DEPTH cycles after the in_valid&in_ready edge.
- Flush is registered-synchronous and takes priority over everything except reset:
  - At the edge: all valid=0, all ctrl=0, payload per CLEAR_DATA.
  - Nothing is accepted that cycle, and occupancy=0 the next cycle.
  - Output handshake during a flush cycle: if out_valid&out_ready, the output transfer still counts as consumed; the entry is not replayed.
- reset behaves identically to flush and overrides it.
- Occupancy is a registered counter: +1 on accept, -1 on output transfer, unchanged when both occur. It is forced to 0 on flush or reset. It must always equal the popcount of the valid bits (bench assertion).
- Ordering: entries leave in acceptance order. There is no duplication or loss except by flush.
- DEPTH=1, COLLAPSE=1: behaves as a stage register with stall (hold) and flush (bubble), i.e. the decode-to-execute behaviour plus stall.
- Full (occupancy=DEPTH) with out_ready=1, COLLAPSE=1: accepts and emits in the same cycle, so occupancy stays DEPTH.

Decomposition:
- Shared package pipe_pkg holds:
  - MAX_DEPTH=8 and the occupancy width constant.
  - The slot_t struct (valid, ctrl, data), parametrised via localparams in the instantiating module.
- One natural sub-module, pipe_slot: a single valid/ctrl/data register with load, kill and CLEAR_DATA behaviour.
- pipe_stage_chain generates DEPTH instances of pipe_slot, plus the ready chain and the occupancy counter.

Test Plan:
- DEPTH=3, COLLAPSE=1, out_ready=1: stream ctrl=1..5 on consecutive cycles. Expect out_ctrl 1..5 on cycles 3..7 and occupancy steady at 3.
- DEPTH=3, COLLAPSE=1: hold out_ready=0 for 4 cycles while pushing A,B,C,D.
  - Expect in_ready=1 for A,B,C, then 0.
  - Expect occupancy=3 and A held at the output.
  - Release out_ready: expect A,B,C,D in order.
- DEPTH=3, COLLAPSE=0: entry at slot 0 only, out_ready=0, out_valid=0. Expect the entry to advance (no freeze while the output is empty). Then fill the chain, drop out_ready, and expect every slot frozen and in_ready=0.
- Flush with occupancy=2 and in_valid=1 on data 0xDEAD:
  - Next cycle: occupancy=0, out_valid=0, out_ctrl=0; 0xDEAD is never emitted.
  - CLEAR_DATA=1: out_data=0.
  - CLEAR_DATA=0: out_data is unchanged.
- Assert reset mid-stream with out_ready=1 and flush=1 together. Expect the reset values; in_ready=0 during reset and 1 on the first cycle after release.
- DEPTH=1: compare against a golden stage register with hold/flush under 1000 random in_valid/out_ready/flush cycles. There must be zero mismatches, and occupancy must equal the valid-bit popcount throughout.

Source files
------------

// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants and helpers for the pipeline slot chain.
package pipe_pkg;

    // Largest chain supported and the width of the occupancy counter (0..8).
    localparam int MAX_DEPTH = 8;
    localparam int OCC_W     = 4;

    // Occupancy update: +1 on accept, -1 on emit, unchanged when both or neither.
    function automatic logic [OCC_W-1:0] occNext(input logic [OCC_W-1:0] occ,
                                                 input logic             inc,
                                                 input logic             dec);
        logic [OCC_W-1:0] res;
        res = occ;
        if (inc && !dec) res = occ + OCC_W'(1);
        if (!inc && dec) res = occ - OCC_W'(1);
        return res;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for the pipeline slot chain.
// Valid/ready: an entry moves across a boundary on a rising clk edge where
// valid and ready are both high; valid never waits on ready, and in_ready is
// combinational but independent of in_valid. flush kills everything in flight
// and blocks input for the cycle in which it is high.
interface pipe_stage_chain_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 64
);
    import pipe_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [CTRL_W-1:0]   in_ctrl;
    logic [DATA_W-1:0]   in_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [CTRL_W-1:0]   out_ctrl;
    logic [DATA_W-1:0]   out_data;
    logic [OCC_W-1:0]    occupancy;

    // Upstream/control side: drives the input entry, flush and out_ready.
    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    // The chain itself.
    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

endinterface

// File: rtl/pipe_stage_chain_slot.sv
// One pipeline slot: valid/ctrl/data register with load, kill and optional
// payload clearing. ctrl is zero whenever the slot is empty.
module pipe_slot #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 64,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              kill,
    input  logic              load,
    input  logic              upValid,
    input  logic [CTRL_W-1:0] upCtrl,
    input  logic [DATA_W-1:0] upData,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Valid and control: killed to empty, loaded from upstream, or held.
    always_ff @(posedge clk) begin
        if (kill) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= upValid;
            ctrl  <= upValid ? upCtrl : '0;
        end
    end

    // Payload: cleared on kill only when CLEAR_DATA, otherwise it just holds.
    always_ff @(posedge clk) begin
        if (kill) begin
            if (CLEAR_DATA) data <= '0;
        end else if (load) begin
            data <= upData;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH valid/ready pipeline slots with flush, stall and optional
// bubble collapse, plus a registered occupancy counter.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 1,
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 64,
    parameter bit CLEAR_DATA = 1'b0,
    parameter bit COLLAPSE   = 1'b1
) (
    input logic               clk,
    input logic               reset,
    pipe_stage_chain_if.slave bus
);

    localparam int DEPTH_C = (DEPTH < 1) ? 1 : ((DEPTH > MAX_DEPTH) ? MAX_DEPTH : DEPTH);

    logic [DEPTH_C-1:0] slotValid;
    logic [CTRL_W-1:0]  slotCtrl [DEPTH_C];
    logic [DATA_W-1:0]  slotData [DEPTH_C];
    logic [DEPTH_C-1:0] ready;
    logic               kill;
    logic               inReady;
    logic               accept;
    logic               emit;
    logic [OCC_W-1:0]   occ;

    // Reset and flush both empty the chain; reset simply also covers flush.
    assign kill    = reset | bus.flush;
    assign inReady = ready[0] & ~bus.flush & ~reset;
    assign accept  = bus.in_valid & inReady;
    assign emit    = slotValid[DEPTH_C-1] & bus.out_ready;

    for (genvar i = 0; i < DEPTH_C; i++) begin : g_slot
        // Ready chain: collapse lets an empty slot fill past a stall further on;
        // without collapse every slot moves only when the output moves.
        if (COLLAPSE) begin : g_col
            if (i == DEPTH_C - 1) begin : g_last
                assign ready[i] = ~slotValid[i] | bus.out_ready;
            end else begin : g_mid
                assign ready[i] = ~slotValid[i] | ready[i+1];
            end
        end else begin : g_frz
            assign ready[i] = bus.out_ready | ~slotValid[DEPTH_C-1];
        end

        // Slot 0 takes the accepted input; later slots take their predecessor.
        if (i == 0) begin : g_head
            pipe_slot #(
                .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)
            ) u_slot (
                .clk(clk), .kill(kill), .load(ready[i]),
                .upValid(accept), .upCtrl(bus.in_ctrl), .upData(bus.in_data),
                .valid(slotValid[i]), .ctrl(slotCtrl[i]), .data(slotData[i])
            );
        end else begin : g_tail
            pipe_slot #(
                .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)
            ) u_slot (
                .clk(clk), .kill(kill), .load(ready[i]),
                .upValid(slotValid[i-1]), .upCtrl(slotCtrl[i-1]), .upData(slotData[i-1]),
                .valid(slotValid[i]), .ctrl(slotCtrl[i]), .data(slotData[i])
            );
        end
    end

    // Occupancy tracks accepts minus emits and is cleared with the chain.
    always_ff @(posedge clk) begin
        if (kill) occ <= '0;
        else      occ <= occNext(occ, accept, emit);
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = slotValid[DEPTH_C-1];
    assign bus.out_ctrl  = slotValid[DEPTH_C-1] ? slotCtrl[DEPTH_C-1] : '0;
    assign bus.out_data  = slotData[DEPTH_C-1];
    assign bus.occupancy = occ;

endmodule
